// File: rtl/fifo_prog.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through read,
// programmable almost-full/almost-empty thresholds, synchronous flush and occupancy output.
module fifo_prog #(
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned FWFT       = 0,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    input  logic [CNT_W-1:0]      af_thresh,
    input  logic [CNT_W-1:0]      ae_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  valid,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      count
);

    localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             wr_ack_q, wr_ack_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_ok, rd_ok;

    assign full        = (count_q == DEPTH_CNT);
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= af_thresh);
    assign almostempty = (count_q <= ae_thresh);
    assign count       = count_q;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    // Flush masks both requests, so it also suppresses the error pulses.
    assign rd_ok = !flush && rd_en && !empty;
    assign wr_ok = !flush && wr_en && (!full || rd_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        wr_ack_d    = 1'b0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            count_d     = count_q + CNT_W'(wr_ok) - CNT_W'(rd_ok);
            wr_ack_d    = wr_ok;
            overflow_d  = wr_en && !wr_ok;
            underflow_d = rd_en && !rd_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Gate the head word while empty so the output is a defined zero after reset.
        assign valid    = !empty;
        assign data_out = empty ? '0 : mem[rd_ptr_q];
    end else begin : g_std
        logic [FIFO_WIDTH-1:0] data_out_q;
        logic                  valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_out_q <= '0;
                valid_q    <= 1'b0;
            end else if (rd_ok) begin
                data_out_q <= mem[rd_ptr_q];
                valid_q    <= 1'b1;
            end else begin
                valid_q    <= 1'b0;
            end
        end

        assign valid    = valid_q;
        assign data_out = data_out_q;
    end

endmodule

// File: tb/tb_fifo_prog.sv
// Directed self-checking bench for fifo_prog: standard depth-8, standard depth-5 and
// FWFT depth-8 instances sharing one clock and reset.
module tb_fifo_prog;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Instance a: standard read, depth 8
    logic        a_flush = 0, a_wr_en = 0, a_rd_en = 0;
    logic [15:0] a_data_in = '0, a_data_out;
    logic [3:0]  a_af = 4'd6, a_ae = 4'd2, a_count;
    logic        a_valid, a_wr_ack, a_overflow, a_underflow, a_full, a_empty, a_afull, a_aempty;

    fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u_std8 (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr_en), .data_in(a_data_in),
        .rd_en(a_rd_en), .af_thresh(a_af), .ae_thresh(a_ae), .data_out(a_data_out),
        .valid(a_valid), .wr_ack(a_wr_ack), .overflow(a_overflow), .underflow(a_underflow),
        .full(a_full), .empty(a_empty), .almostfull(a_afull), .almostempty(a_aempty),
        .count(a_count)
    );

    // Instance b: standard read, depth 5
    logic        b_flush = 0, b_wr_en = 0, b_rd_en = 0;
    logic [15:0] b_data_in = '0, b_data_out;
    logic [2:0]  b_af = 3'd4, b_ae = 3'd1, b_count;
    logic        b_valid, b_wr_ack, b_overflow, b_underflow, b_full, b_empty, b_afull, b_aempty;

    fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(0)) u_std5 (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr_en), .data_in(b_data_in),
        .rd_en(b_rd_en), .af_thresh(b_af), .ae_thresh(b_ae), .data_out(b_data_out),
        .valid(b_valid), .wr_ack(b_wr_ack), .overflow(b_overflow), .underflow(b_underflow),
        .full(b_full), .empty(b_empty), .almostfull(b_afull), .almostempty(b_aempty),
        .count(b_count)
    );

    // Instance c: FWFT, depth 8
    logic        c_flush = 0, c_wr_en = 0, c_rd_en = 0;
    logic [15:0] c_data_in = '0, c_data_out;
    logic [3:0]  c_af = 4'd6, c_ae = 4'd2, c_count;
    logic        c_valid, c_wr_ack, c_overflow, c_underflow, c_full, c_empty, c_afull, c_aempty;

    fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(c_flush), .wr_en(c_wr_en), .data_in(c_data_in),
        .rd_en(c_rd_en), .af_thresh(c_af), .ae_thresh(c_ae), .data_out(c_data_out),
        .valid(c_valid), .wr_ack(c_wr_ack), .overflow(c_overflow), .underflow(c_underflow),
        .full(c_full), .empty(c_empty), .almostfull(c_afull), .almostempty(c_aempty),
        .count(c_count)
    );

    logic [15:0] q5[$];

    initial begin
        // Reset state
        #12;
        check("rst_count", 32'(a_count), 0);
        check("rst_empty", 32'(a_empty), 1);
        check("rst_full", 32'(a_full), 0);
        check("rst_valid", 32'(a_valid), 0);
        check("rst_data", 32'(a_data_out), 0);
        check("rst_pulses", {29'd0, a_wr_ack, a_overflow, a_underflow}, 0);
        check("rst_fwft_valid", 32'(c_valid), 0);
        check("rst_fwft_data", 32'(c_data_out), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        check("idle_count", 32'(a_count), 0);
        check("idle_aempty", 32'(a_aempty), 1);
        check("idle_afull", 32'(a_afull), 0);

        // Fill depth-8 and overflow on the ninth write
        for (int i = 1; i <= 8; i++) begin
            a_wr_en = 1'b1;
            a_data_in = 16'(i);
            tick();
            check("fill_ack", 32'(a_wr_ack), 1);
            check("fill_count", 32'(a_count), 32'(i));
            check("fill_aempty", 32'(a_aempty), 32'(i <= 2));
            check("fill_afull", 32'(a_afull), 32'(i >= 6));
        end
        a_data_in = 16'h0009;
        tick();
        a_wr_en = 1'b0;
        check("ovf_pulse", 32'(a_overflow), 1);
        check("ovf_ack", 32'(a_wr_ack), 0);
        check("ovf_full", 32'(a_full), 1);
        check("ovf_count", 32'(a_count), 8);
        tick();
        check("ovf_single", 32'(a_overflow), 0);

        // Drain in order, then underflow
        for (int i = 1; i <= 8; i++) begin
            a_rd_en = 1'b1;
            tick();
            check("rd_data", 32'(a_data_out), 32'(i));
            check("rd_valid", 32'(a_valid), 1);
            check("rd_count", 32'(8 - i), 32'(a_count));
        end
        tick();
        a_rd_en = 1'b0;
        check("udf_pulse", 32'(a_underflow), 1);
        check("udf_valid", 32'(a_valid), 0);
        check("udf_empty", 32'(a_empty), 1);
        check("udf_hold", 32'(a_data_out), 8);

        // Write-through while full
        for (int i = 1; i <= 8; i++) begin
            a_wr_en = 1'b1;
            a_data_in = 16'(16'h10 + i);
            tick();
        end
        check("wt_prefull", 32'(a_full), 1);
        a_rd_en = 1'b1;
        a_data_in = 16'hAAAA;
        tick();
        a_wr_en = 1'b0;
        check("wt_ack", 32'(a_wr_ack), 1);
        check("wt_ovf", 32'(a_overflow), 0);
        check("wt_count", 32'(a_count), 8);
        check("wt_oldest", 32'(a_data_out), 32'h11);
        for (int i = 2; i <= 8; i++) begin
            tick();
            check("wt_drain", 32'(a_data_out), 32'(16'h10 + i));
        end
        tick();
        check("wt_last", 32'(a_data_out), 32'hAAAA);
        check("wt_empty", 32'(a_empty), 1);

        // Read and write on empty: write taken, read rejected
        a_wr_en = 1'b1;
        a_data_in = 16'h5555;
        tick();
        a_wr_en = 1'b0;
        a_rd_en = 1'b0;
        check("eb_ack", 32'(a_wr_ack), 1);
        check("eb_udf", 32'(a_underflow), 1);
        check("eb_count", 32'(a_count), 1);
        check("eb_valid", 32'(a_valid), 0);

        // Live threshold change
        for (int i = 0; i < 3; i++) begin
            a_wr_en = 1'b1;
            a_data_in = 16'(16'h21 + i);
            tick();
        end
        a_wr_en = 1'b0;
        check("thr_count", 32'(a_count), 4);
        check("thr_afull_lo", 32'(a_afull), 0);
        a_af = 4'd3;
        #1;
        check("thr_afull_hi", 32'(a_afull), 1);
        a_af = 4'd6;
        #1;

        // Flush at count 5 with a concurrent write
        a_wr_en = 1'b1;
        a_data_in = 16'h0024;
        tick();
        check("fl_pre", 32'(a_count), 5);
        a_flush = 1'b1;
        a_data_in = 16'h7777;
        tick();
        a_flush = 1'b0;
        a_wr_en = 1'b0;
        check("fl_count", 32'(a_count), 0);
        check("fl_empty", 32'(a_empty), 1);
        check("fl_ack", 32'(a_wr_ack), 0);
        check("fl_ovf", 32'(a_overflow), 0);
        check("fl_valid", 32'(a_valid), 0);
        check("fl_hold", 32'(a_data_out), 32'hAAAA);
        a_wr_en = 1'b1;
        a_data_in = 16'hBEEF;
        tick();
        a_wr_en = 1'b0;
        a_rd_en = 1'b1;
        tick();
        a_rd_en = 1'b0;
        check("fl_after", 32'(a_data_out), 32'hBEEF);

        // Depth 5: fill, write-through across two wraps, drain past empty
        for (int k = 0; k < 18; k++) begin
            logic wr, rd, rdok, wrok, full_before;
            logic [15:0] exp_d;
            wr = (k < 12);
            rd = (k >= 5);
            full_before = (q5.size() == 5);
            rdok = rd && (q5.size() > 0);
            wrok = wr && (!full_before || rdok);
            exp_d = '0;
            b_wr_en = wr;
            b_rd_en = rd;
            b_data_in = 16'(16'h100 + k);
            if (rdok) exp_d = q5.pop_front();
            if (wrok) q5.push_back(16'(16'h100 + k));
            tick();
            check("d5_count", 32'(b_count), 32'(q5.size()));
            check("d5_full", 32'(b_full), 32'(q5.size() == 5));
            check("d5_valid", 32'(b_valid), 32'(rdok));
            check("d5_ovf", 32'(b_overflow), 32'(wr && !wrok));
            check("d5_udf", 32'(b_underflow), 32'(rd && !rdok));
            if (rdok) check("d5_data", 32'(b_data_out), 32'(exp_d));
        end
        b_wr_en = 1'b0;
        b_rd_en = 1'b0;

        // FWFT: word visible without a read, pop advances
        c_wr_en = 1'b1;
        c_data_in = 16'h1234;
        tick();
        c_wr_en = 1'b0;
        check("ft_valid", 32'(c_valid), 1);
        check("ft_data", 32'(c_data_out), 32'h1234);
        c_rd_en = 1'b1;
        tick();
        c_rd_en = 1'b0;
        check("ft_pop_valid", 32'(c_valid), 0);
        check("ft_pop_empty", 32'(c_empty), 1);
        for (int i = 1; i <= 2; i++) begin
            c_wr_en = 1'b1;
            c_data_in = 16'(16'h40 + i);
            tick();
        end
        c_wr_en = 1'b0;
        check("ft_head", 32'(c_data_out), 32'h41);
        c_rd_en = 1'b1;
        tick();
        c_rd_en = 1'b0;
        check("ft_next", 32'(c_data_out), 32'h42);
        check("ft_cnt", 32'(c_count), 1);

        // Asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            a_wr_en = 1'b1;
            a_data_in = 16'(16'h60 + i);
            tick();
        end
        check("mr_pre", 32'(a_count), 3);
        #2 rst_n = 1'b0;
        #1;
        check("mr_count", 32'(a_count), 0);
        check("mr_empty", 32'(a_empty), 1);
        check("mr_data", 32'(a_data_out), 0);
        check("mr_fwft_count", 32'(c_count), 0);
        a_wr_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_prog.md
Name: fifo_prog

Overview:
- Parametrised synchronous FIFO; next generation of the team's single-clock FIFO.
- Adds the following:
  - Arbitrary depth, including non-power-of-2.
  - Selectable standard or first-word-fall-through (FWFT) read mode.
  - Runtime-programmable almost-full/almost-empty thresholds.
  - Synchronous flush.
  - Occupancy output.
  - Defined write-through-when-full behaviour.
- Sits between producer and consumer blocks in the datapath and is verified by the existing UVM FIFO environment extended for the new features.

Parameters:
- FIFO_WIDTH, 16, data bits per entry (>=1).
- FIFO_DEPTH, 8, number of entries (>=2, any integer).
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through.
- CNT_W, $clog2(FIFO_DEPTH+1), width of count and threshold ports (derived, not overridden).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of contents.
- wr_en  in  1  write request.
- data_in  in  FIFO_WIDTH  write data.
- rd_en  in  1  read request (pop in FWFT mode).
- af_thresh  in  CNT_W  almost-full threshold.
- ae_thresh  in  CNT_W  almost-empty threshold.
- data_out  out  FIFO_WIDTH  read data.
- valid  out  1  data_out holds a valid entry.
- wr_ack  out  1  registered pulse: previous-cycle write accepted.
- overflow  out  1  registered pulse: previous-cycle write rejected.
- underflow  out  1  registered pulse: previous-cycle read rejected.
- full, empty, almostfull, almostempty  out  1 each  status flags.
- count  out  CNT_W  current occupancy.

Behaviour:
- Reset (rst_n=0, async): pointers=0, count=0, data_out=0, valid=0, wr_ack=0, overflow=0, underflow=0; memory contents not reset. Flags then follow count: empty=1, full=0.
- rd_ok = rd_en && !empty.
- wr_ok = wr_en && (!full || rd_ok): write-through when full and read succeeds in the same cycle.
- When empty and both requested: write accepted, read rejected (underflow=1 next cycle); in FWFT the entry becomes visible next cycle.
- count_next = count + wr_ok - rd_ok. Never exceeds FIFO_DEPTH and never underflows.
- Pointers advance by 1 on wr_ok/rd_ok and wrap from FIFO_DEPTH-1 to 0 with explicit compare; no power-of-2 masking.
- wr_ack <= wr_ok; overflow <= wr_en && !wr_ok; underflow <= rd_en && !rd_ok. Each is a single-cycle pulse per request cycle.
- Flags are combinational from count:
  - full = (count==FIFO_DEPTH)
  - empty = (count==0)
  - almostfull = (count >= af_thresh)
  - almostempty = (count <= ae_thresh)
- Thresholds are sampled live; out-of-range values simply saturate the flag meaning.
- FWFT=0 (standard read):
  - On rd_ok, data_out <= mem[rd_ptr] and valid <= 1, i.e. one-cycle latency.
  - Without rd_ok, data_out holds its value and valid <= 0.
- FWFT=1 (FWFT read):
  - data_out = mem[rd_ptr] combinationally; valid = !empty.
  - rd_en pops the displayed word.
  - An entry written into an empty FIFO appears on data_out the cycle after its write edge.
- flush=1 (synchronous, highest priority):
  - Next edge: pointers=0, count=0, wr_ack=0, overflow=0, underflow=0, valid=0.
  - wr_en/rd_en are ignored that cycle and raise no error pulses.
  - data_out holds its value in standard mode.
- Reset or flush mid-stream discards all entries. The first write afterwards lands at index 0.

Test Plan:
- Reset then idle, DEPTH=8 -> count=0, empty=1, full=0, valid=0, data_out=0, all pulses 0.
- Fill 8 writes 0x0001..0x0008, then 9th write -> wr_ack 8 pulses, full=1, count=8, overflow=1 one cycle after 9th; read back 8 -> 0x0001..0x0008 in order, empty=1, 9th read gives underflow=1.
- Full FIFO with wr_en=rd_en=1, data_in=0xAAAA -> wr_ack=1, count stays 8, read returns oldest; after 8 more reads last word is 0xAAAA. On an empty FIFO, both asserted -> wr_ack=1, underflow=1, count=1.
- DEPTH=5, 12 writes interleaved with reads (pointer wrap twice) -> data order preserved, count never >5.
- af_thresh=6, ae_thresh=2: step count 0->8 -> almostempty=1 for count 0..2, almostfull=1 for count 6..8; change af_thresh to 3 at count=4 -> almostfull rises the same cycle.
- FWFT=1: write 0x1234 into empty FIFO -> next cycle valid=1, data_out=0x1234 with no rd_en; rd_en pops -> valid=0.
- Flush at count=5 with wr_en=1 -> next cycle count=0, empty=1, no wr_ack/overflow. Reset asserted mid-burst -> immediate count=0.
